mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Sits directly downstream of the instruction-class decoder and consumes its MDU_op, md, mt and mf-class outputs.
- Holds architectural HI/LO and models fixed multi-cycle mult/div latency with a busy counter.
- Produces the MDU-related D-stage stall request for the hazard unit.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu
DIV_CYCLES, 10, busy duration in cycles for div/divu

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
md  input  1  E-stage instruction is mult/multu/div/divu (start request)
mt  input  1  E-stage instruction is mthi/mtlo
MDU_op  input  3  011 mult, 010 multu, 101 div, 100 divu; with mt: 001 mthi, 000 mtlo
A  input  32  forwarded rs value (E stage)
B  input  32  forwarded rt value (E stage)
d_mdu  input  1  D-stage instruction is md, mf or mt class
HI  output  32  current HI register
LO  output  32  current LO register
busy  output  1  operation in progress
mdu_stall  output  1  stall request to D stage

Behaviour:
- Reset: synchronous. HI=0, LO=0, busy=0, counter=0, pending result discarded. Reset dominates all other inputs, including mid-operation.
- States are IDLE (counter==0) and BUSY (counter!=0). busy = (counter!=0), driven from a register, not combinationally from md.
- Start (IDLE, md=1, edge at end of cycle t):
  - Latch computed result into internal hi_tmp/lo_tmp.
  - Load counter with MULT_CYCLES (MDU_op[2]=0) or DIV_CYCLES (MDU_op[2]=1).
  - busy=1 for cycles t+1 .. t+N.
- Countdown: decrement counter each cycle while BUSY. On the edge where counter==1, HI<=hi_tmp and LO<=lo_tmp, counter<=0. New HI/LO are visible and busy=0 in cycle t+N+1.
- HI/LO hold their old values throughout BUSY.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
  - multu: same as mult, unsigned.
  - div: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: same as div, unsigned.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, div/divu): counter still loads DIV_CYCLES and busy still asserts, but HI/LO stay unchanged at completion.
- mthi/mtlo (IDLE, mt=1): single-cycle write at the edge, HI<=A (op 001) or LO<=A (op 000). busy stays 0.
- md or mt while BUSY: ignored (no restart, no write). Upstream stall makes this unreachable; the bench checks it anyway.
- md and mt both 1: illegal. md wins.
- mdu_stall = d_mdu & (md | busy), combinational. This covers the cycle where start is in E and busy is not yet high.
- mf read (HI/LO outputs) is combinational. The E-stage result mux selects HI or LO.

Test Plan:
- mult A=0xFFFFFFFE(-2), B=3, pulse md one cycle:
  - busy high exactly 5 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle 6 after start.
  - HI/LO unchanged during busy.
- divu A=7, B=2 then div A=0xFFFFFFF9(-7), B=2:
  - First: busy 10 cycles, LO=3, HI=1.
  - Second: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0:
  - busy never asserts.
  - HI=0x12345678, LO=0x9ABCDEF0 one edge after each write.
- div with B=0 after HI=5, LO=6 are set: busy 10 cycles, then HI=5, LO=6 unchanged. div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Stall: d_mdu=1 with md=1 in the same cycle gives mdu_stall=1 immediately. It stays 1 through busy and drops in the cycle busy falls. d_mdu=0 gives mdu_stall=0 throughout.
- Reset asserted in busy cycle 3 of a multu:
  - Next cycle busy=0, HI=0, LO=0.
  - No late write after reset deasserts.
  - A new mult started after reset completes normally.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage of a 5-stage MIPS pipeline.
// Holds architectural HI/LO, computes mult/multu/div/divu results at start,
// and releases them into HI/LO after a fixed busy countdown. Also produces
// the MDU-related D-stage stall request.
//
// Handshake: there is no valid/ready pair here. A start request (md) is
// accepted only in IDLE; while busy, md and mt are ignored, and the hazard
// unit is expected to hold MDU-class instructions in D via mdu_stall.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md,
    input  logic        mt,
    input  logic [2:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_mdu,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        mdu_stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MTHI = 3'b001;
    localparam logic [2:0] OP_MTLO = 3'b000;

    // IDLE <=> counter == 0, BUSY <=> counter != 0; both registers move together.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [31:0]      hi_q, hi_n;
    logic [31:0]      lo_q, lo_n;
    logic [31:0]      hi_tmp_q, hi_tmp_n;
    logic [31:0]      lo_tmp_q, lo_tmp_n;
    // Set when the pending result should be committed (cleared on divide by zero).
    logic             wb_q, wb_n;

    // Arithmetic datapath signals.
    logic        is_signed;
    logic        is_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;
    logic [31:0] hi_calc;
    logic [31:0] lo_calc;

    // Result computation. MDU_op[0] selects signed, MDU_op[2] selects divide.
    // Signed division is done on magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 instead of overflowing.
    always_comb begin
        is_signed = MDU_op[0];
        is_div    = MDU_op[2];

        a_ext = is_signed ? {{32{A[31]}}, A} : {32'b0, A};
        b_ext = is_signed ? {{32{B[31]}}, B} : {32'b0, B};
        prod  = a_ext * b_ext;

        a_neg   = is_signed & A[31];
        b_neg   = is_signed & B[31];
        a_mag   = a_neg ? (~A + 32'd1) : A;
        b_mag   = b_neg ? (~B + 32'd1) : B;
        // Divisor of zero is replaced by one; the result is discarded anyway.
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

        div_by_zero = is_div & (B == 32'd0);

        if (is_div) begin
            hi_calc = rem;
            lo_calc = quot;
        end else begin
            hi_calc = prod[63:32];
            lo_calc = prod[31:0];
        end
    end

    // Next-state logic: start/mt handling in IDLE, countdown and commit in BUSY.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        hi_n     = hi_q;
        lo_n     = lo_q;
        hi_tmp_n = hi_tmp_q;
        lo_tmp_n = lo_tmp_q;
        wb_n     = wb_q;

        case (state_q)
            IDLE: begin
                if (md) begin
                    // md wins over a simultaneous mt.
                    state_n  = BUSY;
                    cnt_n    = is_div ? DIV_LOAD : MULT_LOAD;
                    hi_tmp_n = hi_calc;
                    lo_tmp_n = lo_calc;
                    wb_n     = ~div_by_zero;
                end else if (mt) begin
                    if (MDU_op == OP_MTHI) begin
                        hi_n = A;
                    end else if (MDU_op == OP_MTLO) begin
                        lo_n = A;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_n = IDLE;
                    cnt_n   = CNT_ZERO;
                    if (wb_q) begin
                        hi_n = hi_tmp_q;
                        lo_n = lo_tmp_q;
                    end
                    wb_n = 1'b0;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = CNT_ZERO;
                wb_n    = 1'b0;
            end
        endcase
    end

    // State, counter and HI/LO registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            wb_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            hi_q     <= hi_n;
            lo_q     <= lo_n;
            hi_tmp_q <= hi_tmp_n;
            lo_tmp_q <= lo_tmp_n;
            wb_q     <= wb_n;
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign busy      = (state_q == BUSY);
    // Covers the start cycle itself, before busy has risen.
    assign mdu_stall = d_mdu & (md | busy);

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: scoreboard of expected {HI,LO} pushed at
// start, popped when busy falls.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        md;
    logic        mt;
    logic [2:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        d_mdu;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        mdu_stall;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .md       (md),
        .mt       (mt),
        .MDU_op   (MDU_op),
        .A        (A),
        .B        (B),
        .d_mdu    (d_mdu),
        .HI       (HI),
        .LO       (LO),
        .busy     (busy),
        .mdu_stall(mdu_stall)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: returns {HI,LO} after the operation completes.
    function automatic logic [63:0] model_md(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        case (op)
            3'b011: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
                return p;
            end
            3'b010: begin
                p = {32'b0, a} * {32'b0, b};
                return p;
            end
            3'b101: begin
                if (b == 32'd0) return cur;
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'b100: begin
                if (b == 32'd0) return cur;
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            default: return cur;
        endcase
    endfunction

    // Drive one md start; called just after a posedge. poke injects md+mt
    // during busy, with_mt raises mt alongside the start.
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic dm, input bit poke, input bit with_mt);
        int          n;
        int          want;
        logic [63:0] hold;
        logic [63:0] exp_v;
        want   = op[2] ? 10 : 5;
        md     = 1'b1;
        mt     = with_mt;
        MDU_op = op;
        A      = a;
        B      = b;
        d_mdu  = dm;
        exp_q.push_back(model_md(op, a, b, {m_hi, m_lo}));
        @(negedge clk);
        check({tag, "_stall_start"}, 64'(mdu_stall), 64'(dm));
        check({tag, "_busy_pre"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        md   = 1'b0;
        mt   = 1'b0;
        A    = $urandom;
        B    = $urandom;
        hold = {m_hi, m_lo};
        n    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            check({tag, "_hold"}, {HI, LO}, hold);
            check({tag, "_stall_busy"}, 64'(mdu_stall), 64'(dm));
            if (poke && n == 2) begin
                md     = 1'b1;
                mt     = 1'b1;
                MDU_op = 3'b001;
                A      = 32'hDEADBEEF;
                B      = 32'd3;
            end
            if (poke && n == 3) begin
                md = 1'b0;
                mt = 1'b0;
            end
        end
        check({tag, "_busy_len"}, 64'(n), 64'(want));
        check({tag, "_stall_end"}, 64'(mdu_stall), 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp_v = exp_q.pop_front();
            check({tag, "_hilo"}, {HI, LO}, exp_v);
            m_hi = exp_v[63:32];
            m_lo = exp_v[31:0];
        end
        @(posedge clk);
        #1;
    endtask

    // Single-cycle mthi/mtlo; called just after a posedge, returns just after the next.
    task automatic do_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
        md     = 1'b0;
        mt     = 1'b1;
        MDU_op = op;
        A      = a;
        d_mdu  = 1'b1;
        @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_stall"}, 64'(mdu_stall), 64'd0);
        @(posedge clk);
        #1;
        mt    = 1'b0;
        d_mdu = 1'b0;
        if (op == 3'b001) m_hi = a;
        else m_lo = a;
        check({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    // Main sequence.
    initial begin
        logic [2:0] ops [4];
        logic [31:0] ra, rb;
        int          n;
        ops[0] = 3'b011;
        ops[1] = 3'b010;
        ops[2] = 3'b101;
        ops[3] = 3'b100;
        reset  = 1'b1;
        md     = 1'b0;
        mt     = 1'b0;
        MDU_op = 3'b000;
        A      = 32'd0;
        B      = 32'd0;
        d_mdu  = 1'b1;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(mdu_stall), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        d_mdu = 1'b0;

        run_md("mult", 3'b011, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        check("mult_const", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_md("divu", 3'b100, 32'd7, 32'd2, 1'b1, 1'b0, 1'b0);
        check("divu_const", {m_hi, m_lo}, {32'd1, 32'd3});
        run_md("div", 3'b101, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 1'b0);
        check("div_const", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFFD);

        do_mt("mthi", 3'b001, 32'h12345678);
        do_mt("mtlo", 3'b000, 32'h9ABCDEF0);
        check("mt_const", {HI, LO}, 64'h12345678_9ABCDEF0);

        do_mt("mthi5", 3'b001, 32'd5);
        do_mt("mtlo6", 3'b000, 32'd6);
        run_md("div0", 3'b101, 32'h00001234, 32'd0, 1'b1, 1'b0, 1'b0);
        check("div0_const", {HI, LO}, {32'd5, 32'd6});
        run_md("divu0", 3'b100, 32'hFFFF0000, 32'd0, 1'b0, 1'b0, 1'b0);
        run_md("div_ovf", 3'b101, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        check("div_ovf_const", {HI, LO}, {32'd0, 32'h80000000});
        run_md("md_mt", 3'b010, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
            run_md("rand", ops[$urandom_range(0, 3)], ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // Reset during busy cycle 3 of a multu.
        md     = 1'b1;
        MDU_op = 3'b010;
        A      = 32'hFFFFFFFF;
        B      = 32'hFFFFFFFF;
        d_mdu  = 1'b0;
        exp_q.push_back(model_md(3'b010, A, B, {m_hi, m_lo}));
        @(posedge clk);
        #1;
        md = 1'b0;
        n  = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("rst_mid_busy_seen", 64'(n), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        reset = 1'b0;
        exp_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rst_no_late_busy", 64'(busy), 64'd0);
            check("rst_no_late_hilo", {HI, LO}, 64'd0);
        end
        @(posedge clk);
        #1;
        run_md("post_rst", 3'b011, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
